if_axis_fifo: RTL

IF_AXIS_FIFO -- requirements
Module: if_axis_fifo

---
 rtl/if_axis_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/if_axis_fifo.sv
// CPU-mapped AXI-Stream bridge: a TX FIFO fed by register writes and drained
// by the master stream, and an RX FIFO filled by the slave stream and drained
// by register reads/pops.
// Ports: axis_aclk_i / axis_aresetn_i (async, active-low) clock and reset;
//   addr_i, data_i, data_w_i, data_o, data_access_o  CPU register bus;
//   m_axis_*  TX stream out; s_axis_*  RX stream in; irq_o  level interrupt.
module if_axis_fifo #(
    parameter logic [7:0] SOC_SEGMENT     = 8'hE4,
    parameter logic [7:0] SOC_CLASS       = 8'hA9,
    parameter int         AXIS_DATA_WIDTH = 8,
    parameter int         FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       axis_aclk_i,
    input  logic                       axis_aresetn_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                data_i,
    input  logic                       data_w_i,
    output logic [31:0]                data_o,
    output logic                       data_access_o,
    input  logic                       m_axis_tready_i,
    output logic                       m_axis_tvalid_o,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                       m_axis_tlast_o,
    input  logic                       s_axis_tvalid_i,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                       s_axis_tlast_i,
    output logic                       s_axis_tready_o,
    output logic                       irq_o
);
    localparam int W     = AXIS_DATA_WIDTH;
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int CW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    localparam logic [2:0] SEL_STATUS  = 3'd1;
    localparam logic [2:0] SEL_CONTROL = 3'd2;
    localparam logic [2:0] SEL_TXDATA  = 3'd3;
    localparam logic [2:0] SEL_TXLAST  = 3'd4;
    localparam logic [2:0] SEL_RXDATA  = 3'd5;
    localparam logic [2:0] SEL_RXPOP   = 3'd6;

    // Each entry is {tlast, tdata}.
    logic [W:0]    tx_mem_q [DEPTH];
    logic [W:0]    tx_mem_d [DEPTH];
    logic [W:0]    rx_mem_q [DEPTH];
    logic [W:0]    rx_mem_d [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d;
    logic          rx_ie_q, rx_ie_d;
    logic          tx_ie_q, tx_ie_d;
    logic          irq_q, irq_d;
    logic [31:0]   data_q, data_d;

    logic        hit, wr, tx_wr;
    logic [2:0]  sel;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic [W:0]  tx_head, rx_head;
    logic [31:0] status, rd_val;
    logic        unused_ok;

    assign hit   = (addr_i[31:24] == SOC_SEGMENT) && (addr_i[23:16] == SOC_CLASS);
    assign sel   = addr_i[6:4];
    assign wr    = hit && data_w_i;
    assign tx_wr = wr && ((sel == SEL_TXDATA) || (sel == SEL_TXLAST));

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_head  = tx_mem_q[tx_rptr_q];
    assign rx_head  = rx_mem_q[rx_rptr_q];

    // Fullness is judged at the start of the cycle, so a same-cycle pop
    // never makes room for a push.
    assign tx_push = tx_wr && !tx_full;
    assign tx_pop  = !tx_empty && m_axis_tready_i;
    assign rx_push = s_axis_tvalid_i && s_axis_tready_o;
    assign rx_pop  = wr && (sel == SEL_RXPOP) && !rx_empty;

    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = {sel == SEL_TXLAST, data_i[W-1:0]};
            tx_wptr_d = tx_wptr_q + AW'(1);
        end
        if (tx_pop) tx_rptr_d = tx_rptr_q + AW'(1);
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = {s_axis_tlast_i, s_axis_tdata_i};
            rx_wptr_d = rx_wptr_q + AW'(1);
        end
        if (rx_pop) rx_rptr_d = rx_rptr_q + AW'(1);
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    end

    always_comb begin
        status        = '0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[4]     = tx_ovf_q;
        status[5]     = rx_head[W] && !rx_empty;
        status[15:8]  = 8'(tx_cnt_q);
        status[23:16] = 8'(rx_cnt_q);

        rd_val = '0;
        unique case (sel)
            SEL_STATUS:  rd_val = status;
            SEL_CONTROL: rd_val = {30'd0, tx_ie_q, rx_ie_q};
            SEL_RXDATA:  rd_val = rx_empty ? 32'd0 : 32'(rx_head[W-1:0]);
            default:     rd_val = '0;
        endcase

        data_d   = hit ? rd_val : data_q;
        rx_ie_d  = rx_ie_q;
        tx_ie_d  = tx_ie_q;
        tx_ovf_d = tx_ovf_q;
        if (wr && (sel == SEL_CONTROL)) begin
            rx_ie_d = data_i[0];
            tx_ie_d = data_i[1];
            if (data_i[2]) tx_ovf_d = 1'b0;
        end
        if (tx_wr && tx_full) tx_ovf_d = 1'b1;
        irq_d = (rx_ie_q && !rx_empty) || (tx_ie_q && tx_empty);
    end

    // Storage needs no reset: the cleared counts mark every entry invalid.
    always_ff @(posedge axis_aclk_i) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_ie_q   <= 1'b0;
            tx_ie_q   <= 1'b0;
            irq_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ie_q   <= rx_ie_d;
            tx_ie_q   <= tx_ie_d;
            irq_q     <= irq_d;
            data_q    <= data_d;
        end
    end

    assign data_o          = data_q;
    assign data_access_o   = hit;
    assign irq_o           = irq_q;
    assign m_axis_tvalid_o = !tx_empty;
    assign m_axis_tdata_o  = tx_head[W-1:0];
    assign m_axis_tlast_o  = tx_head[W];
    // Gated with reset so no beat is accepted while the FIFO is being cleared.
    assign s_axis_tready_o = !rx_full && axis_aresetn_i;
    assign unused_ok       = ^{addr_i[15:7], addr_i[3:0], data_i};
endmodule
